wb_32to16_sequencer: RTL and testbench

//  Sequences a 32-bit classic Wishbone master access onto a 16-bit Wishbone slave.

---
 rtl/wb_32to16_sequencer.sv | 217 +++++++++++++++++++++
 tb/tb_wb_32to16_sequencer.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/wb_32to16_sequencer.sv
// ---------------------------------------------------------------------------
// wb_32to16_sequencer
//
// Purpose
//   Bridges a 32-bit classic Wishbone master onto a 16-bit classic Wishbone
//   slave. A 32-bit access becomes one or two 16-bit slave cycles (low half
//   first, then high half) depending on which halves m_sel_i selects. Read
//   data is assembled and a single ack/err/rty is returned to the master.
//
// Ports
//   clk_i, rst_i        clock, synchronous active-high reset
//   m_*_i / m_*_o       32-bit master-facing classic Wishbone slave port
//   s_*_o / s_*_i       16-bit slave-facing classic Wishbone master port
//   dbg_state_o         current sequencer state (IDLE=0, LO=1, HI=2, RESP=3)
//
// Handshake
//   Classic Wishbone: a request is m_cyc_i & m_stb_i held until the one-cycle
//   m_ack_o/m_err_o/m_rty_o pulse. On the slave side s_cyc_o/s_stb_o are held
//   until the first cycle in which s_ack_i/s_err_i/s_rty_i is sampled high;
//   priority is err > rty > ack. s_cyc_o stays high from the low-half phase
//   into the high-half phase so that both halves form one locked bus cycle.
//
// Every output is a register; the response to the master appears one cycle
// after the final slave response is sampled.
// ---------------------------------------------------------------------------
module wb_32to16_sequencer #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        m_cyc_i,
  input  logic        m_stb_i,
  input  logic        m_we_i,
  input  logic [31:0] m_adr_i,
  input  logic [3:0]  m_sel_i,
  input  logic [31:0] m_dat_i,
  output logic [31:0] m_dat_o,
  output logic        m_ack_o,
  output logic        m_err_o,
  output logic        m_rty_o,
  output logic        s_cyc_o,
  output logic        s_stb_o,
  output logic        s_we_o,
  output logic [31:0] s_adr_o,
  output logic [1:0]  s_sel_o,
  output logic [15:0] s_dat_o,
  input  logic [15:0] s_dat_i,
  input  logic        s_ack_i,
  input  logic        s_err_i,
  input  logic        s_rty_i,
  output logic [1:0]  dbg_state_o
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LO   = 2'd1,
    ST_HI   = 2'd2,
    ST_RESP = 2'd3
  } state_t;

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  state_t       r_state;
  logic         r_we;
  logic [3:0]   r_sel;
  logic [31:2]  r_adr;
  logic [31:0]  r_dat;
  logic [15:0]  r_rd_lo;
  logic [CW-1:0] r_cnt;

  logic         w_timeout;
  logic         w_resp_busy;
  logic         w_abort_err;
  logic         w_any_rsp;
  logic         w_hi_needed;
  logic [31:0]  w_rd_final;
  logic         w_unused_adr;

  // Byte-lane bits of the master address never reach the 16-bit bus.
  assign w_unused_adr = ^m_adr_i[1:0];

  // A zero TIMEOUT disables the watchdog entirely.
  assign w_timeout   = (TIMEOUT != 0) && (r_cnt == CW'(TIMEOUT));
  assign w_resp_busy = m_ack_o | m_err_o | m_rty_o;
  assign w_abort_err = s_err_i | w_timeout;
  assign w_any_rsp   = w_abort_err | s_rty_i | s_ack_i;
  assign w_hi_needed = |r_sel[3:2];

  // Read data returned on the final ack. r_rd_lo is cleared on accept, so an
  // unselected low half reads back as zero without extra masking.
  always_comb begin
    w_rd_final = 32'h0;
    if (r_state == ST_LO) begin
      w_rd_final = {16'h0, s_dat_i};
    end else begin
      w_rd_final = {s_dat_i, r_rd_lo};
    end
  end

  assign dbg_state_o = r_state;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= ST_IDLE;
      r_we    <= 1'b0;
      r_sel   <= 4'h0;
      r_adr   <= '0;
      r_dat   <= 32'h0;
      r_rd_lo <= 16'h0;
      r_cnt   <= '0;
      m_dat_o <= 32'h0;
      m_ack_o <= 1'b0;
      m_err_o <= 1'b0;
      m_rty_o <= 1'b0;
      s_cyc_o <= 1'b0;
      s_stb_o <= 1'b0;
      s_we_o  <= 1'b0;
      s_adr_o <= 32'h0;
      s_sel_o <= 2'b00;
      s_dat_o <= 16'h0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_cnt <= '0;
          // The busy guard prevents accepting the same request twice while
          // its response pulse is still visible to the master.
          if (m_cyc_i && m_stb_i && !w_resp_busy) begin
            r_we    <= m_we_i;
            r_sel   <= m_sel_i;
            r_adr   <= m_adr_i[31:2];
            r_dat   <= m_dat_i;
            r_rd_lo <= 16'h0;
            if (|m_sel_i[1:0]) begin
              r_state <= ST_LO;
              s_cyc_o <= 1'b1;
              s_stb_o <= 1'b1;
              s_we_o  <= m_we_i;
              s_adr_o <= {m_adr_i[31:2], 2'b00};
              s_sel_o <= m_sel_i[1:0];
              s_dat_o <= m_dat_i[15:0];
            end else if (|m_sel_i[3:2]) begin
              r_state <= ST_HI;
              s_cyc_o <= 1'b1;
              s_stb_o <= 1'b1;
              s_we_o  <= m_we_i;
              s_adr_o <= {m_adr_i[31:2], 2'b10};
              s_sel_o <= m_sel_i[3:2];
              s_dat_o <= m_dat_i[31:16];
            end else begin
              // No lanes selected: acknowledge without touching the slave.
              r_state <= ST_RESP;
              m_ack_o <= 1'b1;
              m_dat_o <= 32'h0;
            end
          end
        end

        ST_LO, ST_HI: begin
          if (!m_cyc_i) begin
            // Master abandoned the cycle: release the slave, no response.
            r_state <= ST_IDLE;
            s_cyc_o <= 1'b0;
            s_stb_o <= 1'b0;
            s_we_o  <= 1'b0;
            s_adr_o <= 32'h0;
            s_sel_o <= 2'b00;
            s_dat_o <= 16'h0;
          end else if (w_any_rsp) begin
            if (!w_abort_err && !s_rty_i && (r_state == ST_LO) && w_hi_needed) begin
              // Low half acked, continue straight into the high half while
              // keeping s_cyc_o asserted.
              r_state <= ST_HI;
              r_rd_lo <= s_dat_i;
              r_cnt   <= '0;
              s_adr_o <= {r_adr, 2'b10};
              s_sel_o <= r_sel[3:2];
              s_dat_o <= r_dat[31:16];
            end else begin
              r_state <= ST_RESP;
              s_cyc_o <= 1'b0;
              s_stb_o <= 1'b0;
              s_we_o  <= 1'b0;
              s_adr_o <= 32'h0;
              s_sel_o <= 2'b00;
              s_dat_o <= 16'h0;
              if (w_abort_err) begin
                m_err_o <= 1'b1;
                m_dat_o <= 32'h0;
              end else if (s_rty_i) begin
                m_rty_o <= 1'b1;
                m_dat_o <= 32'h0;
              end else begin
                m_ack_o <= 1'b1;
                m_dat_o <= r_we ? 32'h0 : w_rd_final;
              end
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end

        ST_RESP: begin
          r_state <= ST_IDLE;
          m_ack_o <= 1'b0;
          m_err_o <= 1'b0;
          m_rty_o <= 1'b0;
          m_dat_o <= 32'h0;
        end

        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wb_32to16_sequencer.sv
module tb_wb_32to16_sequencer;

  localparam int RSP_ACK  = 0;
  localparam int RSP_ERR  = 1;
  localparam int RSP_RTY  = 2;
  localparam int RSP_NONE = 3;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        m_cyc = 1'b0, m_stb = 1'b0, m_we = 1'b0;
  logic [31:0] m_adr = '0, m_dat_w = '0;
  logic [3:0]  m_sel = '0;
  logic [31:0] m_dat_o;
  logic        m_ack_o, m_err_o, m_rty_o;
  logic        s_cyc_o, s_stb_o, s_we_o;
  logic [31:0] s_adr_o;
  logic [1:0]  s_sel_o;
  logic [15:0] s_dat_o;
  logic [15:0] s_dat = '0;
  logic        s_ack = 1'b0, s_err = 1'b0, s_rty = 1'b0;
  logic [1:0]  dbg_state;

  wb_32to16_sequencer #(.TIMEOUT(4)) dut (
    .clk_i(clk), .rst_i(rst),
    .m_cyc_i(m_cyc), .m_stb_i(m_stb), .m_we_i(m_we), .m_adr_i(m_adr),
    .m_sel_i(m_sel), .m_dat_i(m_dat_w), .m_dat_o(m_dat_o),
    .m_ack_o(m_ack_o), .m_err_o(m_err_o), .m_rty_o(m_rty_o),
    .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o), .s_adr_o(s_adr_o),
    .s_sel_o(s_sel_o), .s_dat_o(s_dat_o), .s_dat_i(s_dat),
    .s_ack_i(s_ack), .s_err_i(s_err), .s_rty_i(s_rty),
    .dbg_state_o(dbg_state)
  );

  // scoreboard counters
  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
    end
  endtask

  // results of the last transfer
  int          res_kind, res_phases, res_lat, res_extra;
  logic [31:0] res_dat;
  logic [31:0] ph_adr [2];
  logic [1:0]  ph_sel [2];
  logic [15:0] ph_dat [2];
  logic        ph_we  [2];

  // driver: one master request, plus a slave model answering each phase
  // after `wt` wait cycles with the response code for that half.
  task automatic run_xfer(input logic we, input logic [3:0] sel, input logic [31:0] adr,
                          input logic [31:0] wdat, input logic [15:0] rlo, input logic [15:0] rhi,
                          input int wt, input int rsp_lo, input int rsp_hi);
    int w;
    int stb_cyc;
    int cur;
    @(negedge clk);
    m_cyc = 1'b1; m_stb = 1'b1; m_we = we; m_sel = sel; m_adr = adr; m_dat_w = wdat;
    res_kind = -1; res_phases = 0; res_lat = -1; res_extra = 0; res_dat = '0;
    for (int i = 0; i < 2; i++) begin
      ph_adr[i] = '0; ph_sel[i] = '0; ph_dat[i] = '0; ph_we[i] = 1'b0;
    end
    w = 0; stb_cyc = -1;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #1;
      if (m_ack_o || m_err_o || m_rty_o) begin
        if ((32'(m_ack_o) + 32'(m_err_o) + 32'(m_rty_o)) != 1) res_kind = 4;
        else if (m_ack_o) res_kind = RSP_ACK;
        else if (m_err_o) res_kind = RSP_ERR;
        else res_kind = RSP_RTY;
        res_dat = m_dat_o;
        res_lat = c - stb_cyc;
        m_cyc = 1'b0; m_stb = 1'b0;
        s_ack = 1'b0; s_err = 1'b0; s_rty = 1'b0;
        break;
      end
      s_ack = 1'b0; s_err = 1'b0; s_rty = 1'b0;
      if (s_stb_o) begin
        if (stb_cyc < 0) stb_cyc = c;
        if (w == 0) begin
          if (res_phases < 2) begin
            ph_adr[res_phases] = s_adr_o; ph_sel[res_phases] = s_sel_o;
            ph_dat[res_phases] = s_dat_o; ph_we[res_phases]  = s_we_o;
          end
          res_phases++;
        end
        cur = s_adr_o[1] ? rsp_hi : rsp_lo;
        if (w >= wt && cur != RSP_NONE) begin
          s_dat = s_adr_o[1] ? rhi : rlo;
          s_ack = (cur == RSP_ACK);
          s_err = (cur == RSP_ERR);
          s_rty = (cur == RSP_RTY);
          w = 0;
        end else begin
          w++;
        end
      end
    end
    m_cyc = 1'b0; m_stb = 1'b0;
    s_ack = 1'b0; s_err = 1'b0; s_rty = 1'b0;
    // no second pulse and a released slave bus afterwards
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      if (m_ack_o || m_err_o || m_rty_o || s_cyc_o || s_stb_o) res_extra++;
    end
  endtask

  typedef struct {
    logic        we;
    logic [3:0]  sel;
    logic [31:0] adr;
    logic [31:0] wdat;
    logic [15:0] rlo;
    logic [15:0] rhi;
    int          wt;
    int          rsp_lo;
    int          rsp_hi;
    int          exp_kind;
    logic [31:0] exp_dat;
    int          exp_ph;
    logic [31:0] exp_adr0;
    logic [1:0]  exp_sel0;
    logic [15:0] exp_sdat0;
    logic [31:0] exp_adr1;
    int          exp_lat;
  } vec_t;

  vec_t vecs [10];

  initial begin
    // two halves, 1 wait each: 2*(1+1) cycles from first stb to response
    vecs[0] = '{1'b0, 4'hF, 32'h100, 32'h0, 16'hBEEF, 16'hCAFE, 1, RSP_ACK, RSP_ACK,
                RSP_ACK, 32'hCAFEBEEF, 2, 32'h100, 2'b11, 16'h0000, 32'h102, 4};
    vecs[1] = '{1'b1, 4'b0011, 32'h100, 32'h12345678, 16'h0, 16'h0, 0, RSP_ACK, RSP_ACK,
                RSP_ACK, 32'h0, 1, 32'h100, 2'b11, 16'h5678, 32'h0, 1};
    vecs[2] = '{1'b0, 4'b1100, 32'h100, 32'h0, 16'h0, 16'hA5A5, 0, RSP_ACK, RSP_ACK,
                RSP_ACK, 32'hA5A50000, 1, 32'h102, 2'b11, 16'h0000, 32'h0, 1};
    vecs[3] = '{1'b1, 4'hF, 32'h100, 32'hDEADBEEF, 16'h0, 16'h0, 0, RSP_ERR, RSP_ACK,
                RSP_ERR, 32'h0, 1, 32'h100, 2'b11, 16'hBEEF, 32'h0, 1};
    vecs[4] = '{1'b0, 4'hF, 32'h200, 32'h0, 16'h1111, 16'h2222, 0, RSP_RTY, RSP_ACK,
                RSP_RTY, 32'h0, 1, 32'h200, 2'b11, 16'h0000, 32'h0, 1};
    vecs[5] = '{1'b0, 4'h0, 32'h300, 32'h0, 16'h1, 16'h2, 0, RSP_ACK, RSP_ACK,
                RSP_ACK, 32'h0, 0, 32'h0, 2'b00, 16'h0, 32'h0, 0};
    vecs[6] = '{1'b0, 4'b0110, 32'h104, 32'h0, 16'h1234, 16'h5678, 0, RSP_ACK, RSP_ACK,
                RSP_ACK, 32'h56781234, 2, 32'h104, 2'b10, 16'h0000, 32'h106, 2};
    vecs[7] = '{1'b1, 4'b1000, 32'h2006, 32'hAABBCCDD, 16'h0, 16'h0, 2, RSP_ACK, RSP_ACK,
                RSP_ACK, 32'h0, 1, 32'h2006, 2'b10, 16'hAABB, 32'h0, 3};
    vecs[8] = '{1'b0, 4'b0001, 32'h13, 32'h0, 16'h77FF, 16'h9999, 0, RSP_ACK, RSP_ACK,
                RSP_ACK, 32'h000077FF, 1, 32'h10, 2'b01, 16'h0000, 32'h0, 1};
    vecs[9] = '{1'b0, 4'hF, 32'h400, 32'h0, 16'h1234, 16'h5678, 1, RSP_ACK, RSP_ERR,
                RSP_ERR, 32'h0, 2, 32'h400, 2'b11, 16'h0000, 32'h402, 4};

    // reset
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_state", 32'(dbg_state), 32'd0);
    chk("reset_m_outs", {m_ack_o, m_err_o, m_rty_o, s_cyc_o, s_stb_o, s_we_o}, 32'h0);
    chk("reset_m_dat", m_dat_o, 32'h0);
    chk("reset_s_bus", {s_adr_o[15:0], s_dat_o}, 32'h0);
    rst = 1'b0;

    // table-driven vectors
    for (int v = 0; v < 10; v++) begin
      run_xfer(vecs[v].we, vecs[v].sel, vecs[v].adr, vecs[v].wdat, vecs[v].rlo, vecs[v].rhi,
               vecs[v].wt, vecs[v].rsp_lo, vecs[v].rsp_hi);
      chk($sformatf("v%0d_kind", v), 32'(res_kind), 32'(vecs[v].exp_kind));
      chk($sformatf("v%0d_mdat", v), res_dat, vecs[v].exp_dat);
      chk($sformatf("v%0d_phases", v), 32'(res_phases), 32'(vecs[v].exp_ph));
      chk($sformatf("v%0d_after", v), 32'(res_extra), 32'd0);
      if (vecs[v].exp_ph > 0) begin
        chk($sformatf("v%0d_adr0", v), ph_adr[0], vecs[v].exp_adr0);
        chk($sformatf("v%0d_sel0", v), 32'(ph_sel[0]), 32'(vecs[v].exp_sel0));
        chk($sformatf("v%0d_sdat0", v), 32'(ph_dat[0]), 32'(vecs[v].exp_sdat0));
        chk($sformatf("v%0d_we0", v), 32'(ph_we[0]), 32'(vecs[v].we));
        chk($sformatf("v%0d_lat", v), 32'(res_lat), 32'(vecs[v].exp_lat));
      end
      if (vecs[v].exp_ph > 1) begin
        chk($sformatf("v%0d_adr1", v), ph_adr[1], vecs[v].exp_adr1);
      end
    end

    // watchdog: silent slave, error 5 cycles after stb rises (TIMEOUT=4)
    run_xfer(1'b1, 4'hF, 32'h500, 32'h01020304, 16'h0, 16'h0, 0, RSP_NONE, RSP_NONE);
    chk("tmo_kind", 32'(res_kind), 32'(RSP_ERR));
    chk("tmo_lat", 32'(res_lat), 32'd5);
    chk("tmo_phases", 32'(res_phases), 32'd1);
    chk("tmo_after", 32'(res_extra), 32'd0);

    // reset while the high half is in progress
    @(negedge clk);
    m_cyc = 1'b1; m_stb = 1'b1; m_we = 1'b0; m_sel = 4'hF; m_adr = 32'h600; m_dat_w = 32'h0;
    @(posedge clk); #1;
    chk("rst_lo_stb", {s_stb_o, s_adr_o[15:0]}, {15'h0, 1'b1, 16'h0600});
    s_ack = 1'b1; s_dat = 16'h1111;
    @(posedge clk); #1;
    s_ack = 1'b0;
    chk("rst_hi_stb", {s_stb_o, s_adr_o[15:0]}, {15'h0, 1'b1, 16'h0602});
    rst = 1'b1;
    @(posedge clk); #1;
    chk("rst_mid_ctrl", {dbg_state, m_ack_o, m_err_o, m_rty_o, s_cyc_o, s_stb_o, s_we_o, s_sel_o},
        32'h0);
    chk("rst_mid_data", {s_adr_o[15:0], s_dat_o}, 32'h0);
    chk("rst_mid_mdat", m_dat_o, 32'h0);
    rst = 1'b0; m_cyc = 1'b0; m_stb = 1'b0;
    repeat (2) @(posedge clk);

    // master drops the cycle during the low half
    @(negedge clk);
    m_cyc = 1'b1; m_stb = 1'b1; m_we = 1'b1; m_sel = 4'hF; m_adr = 32'h700; m_dat_w = 32'hFFFF0000;
    @(posedge clk); #1;
    chk("drop_lo_stb", 32'(s_stb_o), 32'd1);
    m_cyc = 1'b0; m_stb = 1'b0;
    @(posedge clk); #1;
    chk("drop_s_cyc", {s_cyc_o, s_stb_o}, 32'h0);
    res_extra = 0;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      if (m_ack_o || m_err_o || m_rty_o || s_cyc_o) res_extra++;
    end
    chk("drop_no_resp", 32'(res_extra), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
